// File: rtl/sdx_kernel_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : sdx_kernel_ctrl_multi
// Brief    : ap_ctrl_chain controller fanning one host start out to N channels
//            and aggregating their done pulses into ap_done.
// Revision : 1.0 - initial release
// ============================================================================
module sdx_kernel_ctrl_multi #(
    parameter int unsigned C_NUM_CHANNELS    = 4,
    parameter int unsigned C_XFER_SIZE_WIDTH = 32,
    parameter int unsigned C_DEFAULT_LENGTH  = 16384,
    parameter int unsigned C_CYCLE_CNT_WIDTH = 64
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    input  logic                         ap_continue,
    output logic                         ap_idle,
    output logic                         ap_ready,
    output logic                         ap_done,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    input  logic [C_NUM_CHANNELS-1:0]    ch_enable,
    output logic [C_NUM_CHANNELS-1:0]    ch_start,
    output logic [C_XFER_SIZE_WIDTH-1:0] ch_xfer_size,
    input  logic [C_NUM_CHANNELS-1:0]    ch_done,
    output logic [C_NUM_CHANNELS-1:0]    ch_done_status,
    output logic [C_CYCLE_CNT_WIDTH-1:0] cycle_count
);

    localparam logic [C_XFER_SIZE_WIDTH-1:0] c_default_xfer = C_XFER_SIZE_WIDTH'(C_DEFAULT_LENGTH);
    localparam logic [C_CYCLE_CNT_WIDTH-1:0] c_cnt_one      = C_CYCLE_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic                           r_ap_start;
    logic                           w_start_pulse;
    logic                           w_running;
    logic [C_NUM_CHANNELS-1:0]      r_en_mask;
    logic [C_NUM_CHANNELS-1:0]      r_status;
    logic [C_XFER_SIZE_WIDTH-1:0]   r_xfer_size;
    logic [C_CYCLE_CNT_WIDTH-1:0]   r_cycle_cnt;

    assign w_start_pulse = ap_start & ~r_ap_start;
    assign w_running     = (r_state == S_START) || (r_state == S_BUSY);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_pulse) w_state_next = S_START;
            S_START: w_state_next = S_BUSY;
            // Compare against the registered status so the last done costs two cycles to ap_done.
            S_BUSY:  if (r_status == r_en_mask) w_state_next = S_DONE;
            S_DONE:  if (ap_continue) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_ap_start  <= 1'b0;
            r_en_mask   <= '0;
            r_status    <= '0;
            r_xfer_size <= c_default_xfer;
            r_cycle_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ap_start <= ap_start;
            if ((r_state == S_IDLE) && w_start_pulse) begin
                r_en_mask   <= ch_enable;
                r_xfer_size <= (ctrl_xfer_size_in_bytes == '0) ? c_default_xfer
                                                               : ctrl_xfer_size_in_bytes;
                r_status    <= '0;
                r_cycle_cnt <= '0;
            end else if (w_running) begin
                r_status <= r_status | (ch_done & r_en_mask);
                if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
            end
        end
    end

    assign ap_idle        = (r_state == S_IDLE);
    assign ap_ready       = (r_state == S_START);
    assign ap_done        = (r_state == S_DONE);
    assign ch_start       = (r_state == S_START) ? r_en_mask : '0;
    assign ch_xfer_size   = r_xfer_size;
    assign ch_done_status = r_status;
    assign cycle_count    = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdx_kernel_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdx_kernel_ctrl_multi
// Brief    : Directed self-checking bench for sdx_kernel_ctrl_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdx_kernel_ctrl_multi;

    logic        ap_clk;
    logic        areset;
    logic        ap_start;
    logic        ap_continue;
    logic        ap_idle;
    logic        ap_ready;
    logic        ap_done;
    logic [31:0] ctrl_xfer_size_in_bytes;
    logic [3:0]  ch_enable;
    logic [3:0]  ch_start;
    logic [31:0] ch_xfer_size;
    logic [3:0]  ch_done;
    logic [3:0]  ch_done_status;
    logic [63:0] cycle_count;

    int n_checks = 0;
    int n_pass   = 0;

    sdx_kernel_ctrl_multi #(
        .C_NUM_CHANNELS    (4),
        .C_XFER_SIZE_WIDTH (32),
        .C_DEFAULT_LENGTH  (16384),
        .C_CYCLE_CNT_WIDTH (64)
    ) u_dut (
        .ap_clk                  (ap_clk),
        .areset                  (areset),
        .ap_start                (ap_start),
        .ap_continue             (ap_continue),
        .ap_idle                 (ap_idle),
        .ap_ready                (ap_ready),
        .ap_done                 (ap_done),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ch_enable               (ch_enable),
        .ch_start                (ch_start),
        .ch_xfer_size            (ch_xfer_size),
        .ch_done                 (ch_done),
        .ch_done_status          (ch_done_status),
        .cycle_count             (cycle_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge ap_clk);
    endtask

    // Leaves the bench at the falling edge of the START cycle.
    task automatic start_run(input logic [3:0] en, input logic [31:0] size, input bit hold);
        ch_enable               = en;
        ctrl_xfer_size_in_bytes = size;
        ap_start                = 1'b1;
        step();
        if (!hold) ap_start = 1'b0;
    endtask

    task automatic acknowledge(input string tag);
        ap_continue = 1'b1;
        step();
        ap_continue = 1'b0;
        check({tag, "_idle"}, 64'(ap_idle), 64'd1);
        check({tag, "_done_clr"}, 64'(ap_done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1; ap_start = 1'b0; ap_continue = 1'b0;
        ctrl_xfer_size_in_bytes = 32'd0; ch_enable = 4'h0; ch_done = 4'h0;
        repeat (3) step();
        areset = 1'b0;
        check("rst_idle",  64'(ap_idle),        64'd1);
        check("rst_ready", 64'(ap_ready),       64'd0);
        check("rst_done",  64'(ap_done),        64'd0);
        check("rst_start", 64'(ch_start),       64'd0);
        check("rst_status",64'(ch_done_status), 64'd0);
        check("rst_cnt",   cycle_count,         64'd0);
        check("rst_size",  64'(ch_xfer_size),   64'd16384);
        step();

        // 1: all channels, done offsets 5,9,3,12 after the start was accepted.
        start_run(4'hF, 32'd4096, 1'b0);
        check("t1_ch_start", 64'(ch_start), 64'hF);
        check("t1_ready",    64'(ap_ready), 64'd1);
        check("t1_idle",     64'(ap_idle),  64'd0);
        check("t1_size",     64'(ch_xfer_size), 64'd4096);
        for (int j = 1; j <= 15; j++) begin
            step();
            if (j == 1) begin
                check("t1_ch_start_off", 64'(ch_start), 64'h0);
                check("t1_ready_off",    64'(ap_ready), 64'd0);
            end
            if (j == 14) check("t1_done_early", 64'(ap_done), 64'd0);
            ch_done = {(j == 13), (j == 4), (j == 10), (j == 6)};
        end
        check("t1_done",   64'(ap_done),        64'd1);
        check("t1_cnt",    cycle_count,         64'd15);
        check("t1_status", 64'(ch_done_status), 64'hF);
        repeat (3) step();
        check("t1_done_hold", 64'(ap_done), 64'd1);
        check("t1_cnt_hold",  cycle_count,  64'd15);
        acknowledge("t1");
        check("t1_cnt_frozen", cycle_count, 64'd15);
        step();

        // 2: mask 0101, disabled-channel and repeat pulses must not finish the run.
        start_run(4'b0101, 32'd64, 1'b0);
        check("t2_ch_start", 64'(ch_start), 64'h5);
        for (int j = 1; j <= 7; j++) begin
            step();
            if (j == 5) begin
                check("t2_busy",        64'(ap_done),        64'd0);
                check("t2_status_part", 64'(ch_done_status), 64'h1);
            end
            if (j == 6) check("t2_done_early", 64'(ap_done), 64'd0);
            case (j)
                1: ch_done = 4'b1010;
                3: ch_done = 4'b0001;
                4: ch_done = 4'b1011;
                5: ch_done = 4'b0100;
                default: ch_done = 4'b0000;
            endcase
        end
        check("t2_done",   64'(ap_done),        64'd1);
        check("t2_status", 64'(ch_done_status), 64'h5);
        ch_done = 4'hF;
        step();
        ch_done = 4'h0;
        check("t2_status_hold", 64'(ch_done_status), 64'h5);
        acknowledge("t2");
        step();

        // 3/4: zero size falls back to default, empty mask completes immediately.
        start_run(4'h0, 32'd0, 1'b0);
        check("t3_size_default", 64'(ch_xfer_size), 64'd16384);
        check("t4_no_start",     64'(ch_start),     64'h0);
        step();
        check("t4_done_early", 64'(ap_done), 64'd0);
        step();
        check("t4_done",     64'(ap_done),  64'd1);
        check("t4_cnt",      cycle_count,   64'd2);
        check("t4_start_lo", 64'(ch_start), 64'h0);
        acknowledge("t4");
        step();
        start_run(4'h0, 32'hFFFF_FFFF, 1'b0);
        check("t3_size_max", 64'(ch_xfer_size), 64'hFFFF_FFFF);
        repeat (2) step();
        check("t3_size_hold", 64'(ch_xfer_size), 64'hFFFF_FFFF);
        acknowledge("t3");
        step();

        // 5: reset with two of four channels done, then a clean run.
        start_run(4'hF, 32'd128, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            step();
            ch_done = (j == 2) ? 4'b0011 : 4'b0000;
        end
        check("t5_status_part", 64'(ch_done_status), 64'h3);
        areset = 1'b1;
        step();
        areset = 1'b0;
        check("t5_idle",   64'(ap_idle),        64'd1);
        check("t5_status", 64'(ch_done_status), 64'h0);
        check("t5_done",   64'(ap_done),        64'd0);
        check("t5_start",  64'(ch_start),       64'h0);
        check("t5_cnt",    cycle_count,         64'd0);
        check("t5_size",   64'(ch_xfer_size),   64'd16384);
        step();
        start_run(4'hF, 32'd256, 1'b0);
        check("t5_rerun_start", 64'(ch_start), 64'hF);
        for (int j = 1; j <= 4; j++) begin
            step();
            ch_done = (j == 2) ? 4'hF : 4'h0;
        end
        check("t5_rerun_done", 64'(ap_done), 64'd1);
        check("t5_rerun_cnt",  cycle_count,  64'd4);
        acknowledge("t5");
        step();

        // 6: a held start level must not retrigger; a fresh edge must.
        start_run(4'h0, 32'd8, 1'b1);
        check("t6_ready", 64'(ap_ready), 64'd1);
        repeat (2) step();
        check("t6_done", 64'(ap_done), 64'd1);
        acknowledge("t6");
        repeat (3) begin
            step();
            check("t6_no_rerun_idle",  64'(ap_idle),  64'd1);
            check("t6_no_rerun_ready", 64'(ap_ready), 64'd0);
        end
        ap_start = 1'b0;
        step();
        start_run(4'b0010, 32'd8, 1'b0);
        check("t6_new_ready", 64'(ap_ready), 64'd1);
        check("t6_new_start", 64'(ch_start), 64'h2);
        step();
        ch_done = 4'b0010;
        step();
        ch_done = 4'b0000;
        repeat (2) step();
        check("t6_new_done", 64'(ap_done), 64'd1);
        acknowledge("t6_new");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
